// File: rtl/bus_tx_arbiter.sv
// rtl/bus_tx_arbiter.sv - shares the 8-bit Arduino out_bus between PC, MAR and MDR word sources
//
// Arbitrates pending word requests, latches the granted word and sends it
// MSB byte first, holding each byte until ard_receive_ready accepts it.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_pc/req_mar/req_mdr      level requests, held until the matching done_*
//   word_pc/word_mar/word_mdr   source words, sampled only in the grant cycle
//   ard_receive_ready           Arduino accepted the presented byte this cycle
//   out_bus                     byte presented (0 when no select is high)
//   bus_pc/bus_mar/bus_mdr      one-hot tag of the byte on out_bus
//   done_pc/done_mar/done_mdr   1-cycle pulse after the last byte is accepted
//   busy                        arbiter not idle
//   error                       sticky byte-acknowledge timeout
module bus_tx_arbiter #(
   parameter int NBYTES  = 2,
   parameter int RR      = 1,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_pc,
   input  logic                  req_mar,
   input  logic                  req_mdr,
   input  logic [8*NBYTES-1:0]   word_pc,
   input  logic [8*NBYTES-1:0]   word_mar,
   input  logic [8*NBYTES-1:0]   word_mdr,
   input  logic                  ard_receive_ready,
   output logic [7:0]            out_bus,
   output logic                  bus_pc,
   output logic                  bus_mar,
   output logic                  bus_mdr,
   output logic                  done_pc,
   output logic                  done_mar,
   output logic                  done_mdr,
   output logic                  busy,
   output logic                  error
);

   localparam int WW  = 8 * NBYTES;
   localparam int BCW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   // wait_cnt only ever needs to reach TIMEOUT-1
   localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [BCW-1:0] BC_LAST   = BCW'(NBYTES - 1);
   localparam logic [TCW-1:0] WAIT_LAST = TCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   // source index encoding: 0 = PC, 1 = MAR, 2 = MDR
   typedef enum logic [1:0] {IDLE, SEND, DONE, ERR} state_t;

   state_t          state, state_nx;
   logic [WW-1:0]   shreg, shreg_nx;
   logic [BCW-1:0]  byte_cnt, byte_cnt_nx;
   logic [TCW-1:0]  wait_cnt, wait_cnt_nx;
   logic [1:0]      owner, owner_nx;
   logic [1:0]      rr_ptr, rr_ptr_nx;

   logic [2:0]      reqs;
   logic            gnt_valid;
   logic [1:0]      gnt_idx;
   logic [1:0]      start;
   logic [1:0]      cand;
   logic [WW-1:0]   gnt_word;

   assign reqs = {req_mdr, req_mar, req_pc};

   // Search from 'start' in PC->MAR->MDR->PC order. The loop walks the order
   // backwards so the first requester in search order is the last one written.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = 2'd0;
      cand      = 2'd0;
      start     = (RR != 0) ? rr_ptr : 2'd0;
      for (int k = 2; k >= 0; k--) begin
         cand = 2'((int'(start) + k) % 3);
         if (reqs[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      case (gnt_idx)
         2'd0:    gnt_word = word_pc;
         2'd1:    gnt_word = word_mar;
         default: gnt_word = word_mdr;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         shreg    <= '0;
         byte_cnt <= '0;
         wait_cnt <= '0;
         owner    <= 2'd0;
         rr_ptr   <= 2'd0;
      end else begin
         state    <= state_nx;
         shreg    <= shreg_nx;
         byte_cnt <= byte_cnt_nx;
         wait_cnt <= wait_cnt_nx;
         owner    <= owner_nx;
         rr_ptr   <= rr_ptr_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      shreg_nx    = shreg;
      byte_cnt_nx = byte_cnt;
      wait_cnt_nx = wait_cnt;
      owner_nx    = owner;
      rr_ptr_nx   = rr_ptr;
      case (state)
         IDLE: begin
            if (gnt_valid) begin
               owner_nx    = gnt_idx;
               shreg_nx    = gnt_word;
               byte_cnt_nx = BC_LAST;
               wait_cnt_nx = '0;
               rr_ptr_nx   = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
               state_nx    = SEND;
            end
         end
         SEND: begin
            if (ard_receive_ready) begin
               if (byte_cnt != '0) begin
                  shreg_nx    = shreg << 8;
                  byte_cnt_nx = byte_cnt - 1'b1;
                  wait_cnt_nx = '0;
               end else begin
                  state_nx = DONE;
               end
            end else if ((TIMEOUT > 0) && (wait_cnt == WAIT_LAST)) begin
               state_nx = ERR;
            end else begin
               // with TIMEOUT disabled this simply wraps, which is harmless
               wait_cnt_nx = wait_cnt + 1'b1;
            end
         end
         DONE:    state_nx = IDLE;
         ERR:     state_nx = ERR;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs decode straight from registered state, so nothing on the
   // Arduino side depends combinationally on the request/ready inputs.
   always_comb begin
      out_bus  = (state == SEND) ? shreg[WW-1 -: 8] : 8'h00;
      bus_pc   = (state == SEND) && (owner == 2'd0);
      bus_mar  = (state == SEND) && (owner == 2'd1);
      bus_mdr  = (state == SEND) && (owner == 2'd2);
      done_pc  = (state == DONE) && (owner == 2'd0);
      done_mar = (state == DONE) && (owner == 2'd1);
      done_mdr = (state == DONE) && (owner == 2'd2);
      busy     = (state != IDLE);
      error    = (state == ERR);
   end

endmodule

// File: tb/tb_bus_tx_arbiter.sv
// tb/tb_bus_tx_arbiter.sv - self-checking bench for bus_tx_arbiter (round-robin and fixed-priority instances)
module tb_bus_tx_arbiter;

   localparam int TMO = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, req_pc, req_mar, req_mdr, rdy;
   logic [15:0] w_pc, w_mar, w_mdr;

   // index 0: RR=1 instance, index 1: RR=0 instance
   logic [7:0]  ob[2];
   logic        bpc[2], bmar[2], bmdr[2], dpc[2], dmar[2], dmdr[2], bsy[2], err[2];

   bus_tx_arbiter #(.NBYTES(2), .RR(1), .TIMEOUT(TMO)) dut_rr (
      .clk(clk), .rst(rst), .req_pc(req_pc), .req_mar(req_mar), .req_mdr(req_mdr),
      .word_pc(w_pc), .word_mar(w_mar), .word_mdr(w_mdr), .ard_receive_ready(rdy),
      .out_bus(ob[0]), .bus_pc(bpc[0]), .bus_mar(bmar[0]), .bus_mdr(bmdr[0]),
      .done_pc(dpc[0]), .done_mar(dmar[0]), .done_mdr(dmdr[0]), .busy(bsy[0]), .error(err[0]));

   bus_tx_arbiter #(.NBYTES(2), .RR(0), .TIMEOUT(TMO)) dut_fp (
      .clk(clk), .rst(rst), .req_pc(req_pc), .req_mar(req_mar), .req_mdr(req_mdr),
      .word_pc(w_pc), .word_mar(w_mar), .word_mdr(w_mdr), .ard_receive_ready(rdy),
      .out_bus(ob[1]), .bus_pc(bpc[1]), .bus_mar(bmar[1]), .bus_mdr(bmdr[1]),
      .done_pc(dpc[1]), .done_mar(dmar[1]), .done_mdr(dmdr[1]), .busy(bsy[1]), .error(err[1]));

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input int d, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got %h expected %h", name, d, got, exp);
      end
   endtask

   // Transaction-level reference: a word in flight with bytes left and a
   // no-ack streak counter, a pending done owner, a sticky error and the
   // round-robin start index.
   typedef struct {
      bit          active;
      int          owner;
      logic [15:0] word;
      int          left;
      int          waited;
      int          done_of;
      bit          err;
      int          ptr;
   } mdl_t;

   mdl_t        m[2];
   bit          mr[3];
   logic [15:0] mw[3];
   int          mstart, mg;

   always @(posedge clk) begin
      mr = '{req_pc, req_mar, req_mdr};
      mw = '{w_pc, w_mar, w_mdr};
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m[i].active  = 0;
            m[i].owner   = -1;
            m[i].done_of = -1;
            m[i].err     = 0;
            m[i].ptr     = 0;
            m[i].left    = 0;
            m[i].waited  = 0;
            m[i].word    = 16'h0;
         end else if (m[i].err) begin
            m[i].active = 0;
         end else if (m[i].done_of >= 0) begin
            m[i].done_of = -1;
         end else if (m[i].active) begin
            if (rdy) begin
               if (m[i].left > 1) begin
                  m[i].word   = m[i].word << 8;
                  m[i].left   = m[i].left - 1;
                  m[i].waited = 0;
               end else begin
                  m[i].active  = 0;
                  m[i].done_of = m[i].owner;
               end
            end else begin
               m[i].waited = m[i].waited + 1;
               if (m[i].waited == TMO) begin
                  m[i].err    = 1;
                  m[i].active = 0;
               end
            end
         end else begin
            mstart = (i == 0) ? m[i].ptr : 0;
            mg = -1;
            for (int k = 0; k < 3; k++)
               if (mg < 0 && mr[(mstart + k) % 3]) mg = (mstart + k) % 3;
            if (mg >= 0) begin
               m[i].active = 1;
               m[i].owner  = mg;
               m[i].word   = mw[mg];
               m[i].left   = 2;
               m[i].waited = 0;
               m[i].ptr    = (mg + 1) % 3;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk("out_bus",  i, ob[i],   m[i].active ? {8'h00, m[i].word[15:8]} : 16'h0);
            chk("bus_pc",   i, bpc[i],  m[i].active && m[i].owner == 0);
            chk("bus_mar",  i, bmar[i], m[i].active && m[i].owner == 1);
            chk("bus_mdr",  i, bmdr[i], m[i].active && m[i].owner == 2);
            chk("done_pc",  i, dpc[i],  m[i].done_of == 0);
            chk("done_mar", i, dmar[i], m[i].done_of == 1);
            chk("done_mdr", i, dmdr[i], m[i].done_of == 2);
            chk("busy",     i, bsy[i],  m[i].active || m[i].done_of >= 0 || m[i].err);
            chk("error",    i, err[i],  m[i].err);
            chk("sel_onehot", i, (int'(bpc[i]) + int'(bmar[i]) + int'(bmdr[i])) <= 1, 1'b1);
            chk("idle_bus_zero", i, (!bpc[i] && !bmar[i] && !bmdr[i]) ? ob[i] == 8'h00 : 1'b1, 1'b1);
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   int seq[2][$];
   int exp_rr[4] = '{0, 1, 2, 0};
   int mode;

   initial begin
      rst = 1'b1; req_pc = 0; req_mar = 0; req_mdr = 0; rdy = 0;
      w_pc = 16'h0; w_mar = 16'h0; w_mdr = 16'h0;
      step();
      chk_en = 1'b1;
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("rst_out_bus", i, ob[i], 16'h0);
         chk("rst_busy", i, bsy[i], 1'b0);
         chk("rst_error", i, err[i], 1'b0);
         chk("rst_bus_pc", i, bpc[i], 1'b0);
      end

      // single PC word, ready always high
      req_pc = 1; w_pc = 16'hA55A; rdy = 1;
      step();
      for (int i = 0; i < 2; i++) begin
         chk("t1_byte0", i, ob[i], 16'h00A5);
         chk("t1_sel", i, bpc[i], 1'b1);
      end
      step();
      for (int i = 0; i < 2; i++) chk("t1_byte1", i, ob[i], 16'h005A);
      step();
      for (int i = 0; i < 2; i++) begin
         chk("t1_done", i, dpc[i], 1'b1);
         chk("t1_done_bus", i, ob[i], 16'h0);
         chk("t1_done_busy", i, bsy[i], 1'b1);
      end
      req_pc = 0;
      step();
      for (int i = 0; i < 2; i++) chk("t1_idle_busy", i, bsy[i], 1'b0);

      // all three requesting: RR rotates, fixed priority starves MAR/MDR
      do_reset();
      req_pc = 1; req_mar = 1; req_mdr = 1; rdy = 1;
      w_pc = 16'h1111; w_mar = 16'h2222; w_mdr = 16'h3333;
      for (int c = 0; c < 18; c++) begin
         step();
         for (int i = 0; i < 2; i++) begin
            if (dpc[i])  seq[i].push_back(0);
            if (dmar[i]) seq[i].push_back(1);
            if (dmdr[i]) seq[i].push_back(2);
         end
      end
      for (int i = 0; i < 2; i++) begin
         chk("t23_ndone", i, 16'(seq[i].size()), 16'd4);
         for (int k = 0; k < 4; k++)
            if (seq[i].size() > k)
               chk("t23_order", i, 16'(seq[i][k]), (i == 0) ? 16'(exp_rr[k]) : 16'd0);
      end
      req_pc = 0; req_mar = 0; req_mdr = 0;

      // MDR word with 5 withheld-ready cycles
      do_reset();
      req_mdr = 1; w_mdr = 16'h1234; rdy = 0;
      for (int c = 1; c <= 6; c++) begin
         step();
         for (int i = 0; i < 2; i++) chk("t4_hold12", i, ob[i], 16'h0012);
         if (c == 6) rdy = 1;
      end
      step();
      for (int i = 0; i < 2; i++) chk("t4_byte34", i, ob[i], 16'h0034);
      step();
      for (int i = 0; i < 2; i++) chk("t4_done", i, dmdr[i], 1'b1);
      req_mdr = 0; rdy = 0;

      // timeout after 8 SEND cycles without ready
      do_reset();
      req_pc = 1; w_pc = 16'hCAFE; rdy = 0;
      for (int c = 1; c <= 8; c++) begin
         step();
         for (int i = 0; i < 2; i++) begin
            chk("t5_noerr", i, err[i], 1'b0);
            chk("t5_sel", i, bpc[i], 1'b1);
         end
      end
      step();
      for (int i = 0; i < 2; i++) begin
         chk("t5_err", i, err[i], 1'b1);
         chk("t5_sel_off", i, bpc[i], 1'b0);
         chk("t5_bus_off", i, ob[i], 16'h0);
         chk("t5_nodone", i, dpc[i], 1'b0);
         chk("t5_busy", i, bsy[i], 1'b1);
      end
      req_pc = 0; rdy = 1;
      repeat (3) step();
      for (int i = 0; i < 2; i++) chk("t5_sticky", i, err[i], 1'b1);
      do_reset();
      for (int i = 0; i < 2; i++) chk("t5_cleared", i, err[i], 1'b0);

      // reset mid-word, then restart
      req_mar = 1; w_mar = 16'hBEEF; rdy = 1;
      step();
      for (int i = 0; i < 2; i++) chk("t6_be", i, ob[i], 16'h00BE);
      step();
      for (int i = 0; i < 2; i++) chk("t6_ef", i, ob[i], 16'h00EF);
      rst = 1;
      step();
      rst = 0;
      for (int i = 0; i < 2; i++) begin
         chk("t6_rst_bus", i, ob[i], 16'h0);
         chk("t6_rst_sel", i, bmar[i], 1'b0);
         chk("t6_rst_done", i, dmar[i], 1'b0);
         chk("t6_rst_busy", i, bsy[i], 1'b0);
      end
      step();
      for (int i = 0; i < 2; i++) chk("t6_re_be", i, ob[i], 16'h00BE);
      w_mar = 16'h0000;
      step();
      for (int i = 0; i < 2; i++) chk("t6_re_ef", i, ob[i], 16'h00EF);
      step();
      for (int i = 0; i < 2; i++) chk("t6_done", i, dmar[i], 1'b1);
      req_mar = 0;

      // randomized traffic against the model
      do_reset();
      mode = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         step();
         if (cyc % 64 == 0) mode = $urandom_range(0, 2);
         rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 7) == 0) req_pc  = ~req_pc;
         if ($urandom_range(0, 7) == 0) req_mar = ~req_mar;
         if ($urandom_range(0, 7) == 0) req_mdr = ~req_mdr;
         w_pc  = 16'($urandom);
         w_mar = 16'($urandom);
         w_mdr = 16'($urandom);
         case (mode)
            0:       rdy = ($urandom_range(0, 9) < 9);
            1:       rdy = $urandom_range(0, 1) == 1;
            default: rdy = 1'b0;
         endcase
      end
      rst = 0; req_pc = 0; req_mar = 0; req_mdr = 0; rdy = 1;
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
